bcd_conv_seq: RTL and testbench

BCD_CONV_SEQ -- requirements
Module: bcd_conv_seq

---
 rtl/bcd_conv_seq.sv | 203 ++++++++++++++++++++
 tb/tb_bcd_conv_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_seq.sv
// Sequential binary<->BCD converter.
// Mode 1 divides by ten bit-serially; mode 0 accumulates digits MSD first.
module bcd_conv_seq #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    input  logic [W-1:0]   bin_in,
    input  logic [4*D-1:0] bcd_in,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   bin_out,
    output logic [4*D-1:0] bcd_out,
    output logic           ovf,
    output logic           err
);

    localparam int BCW = $clog2(W);
    localparam int DCW = (D > 1) ? $clog2(D) : 1;

    localparam logic [BCW-1:0] BLAST = BCW'(W - 1);
    localparam logic [DCW-1:0] DLAST = DCW'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Division datapath
    logic [W-1:0]   dvd;
    logic [W-1:0]   quo;
    logic [3:0]     rem;
    logic [BCW-1:0] bit_cnt;
    logic [DCW-1:0] dig_cnt;
    logic [4*D-1:0] work_bcd;

    // Accumulation datapath
    logic [4*D-1:0] bcd_src;
    logic [W-1:0]   acc;
    logic           w_ovf;
    logic           w_err;

    // Combinational step results
    logic [4:0]     rem_sh;
    logic [4:0]     rem_sub;
    logic           rem_ge;
    logic [3:0]     rem_nx;
    logic [W-1:0]   quo_nx;
    logic [4*D-1:0] bcd_fin;
    logic           bit_last;
    logic           dig_last;
    logic           acc_last;
    logic           accept;
    logic [3:0]     digit;
    logic [W+3:0]   acc_x;
    logic [W+3:0]   acc_wide;
    logic           acc_ovf;
    logic           dig_bad;

    // One restoring-division step and the digit it would retire
    always_comb begin
        rem_sh   = {rem, dvd[W-1]};
        rem_sub  = rem_sh - 5'd10;
        rem_ge   = (rem_sh >= 5'd10);
        rem_nx   = rem_ge ? rem_sub[3:0] : rem_sh[3:0];
        quo_nx   = {quo[W-2:0], rem_ge};
        bit_last = (bit_cnt == BLAST);
        dig_last = (dig_cnt == DLAST);
        bcd_fin  = work_bcd;
        bcd_fin[4*dig_cnt +: 4] = rem_nx;
    end

    // One multiply-by-ten-and-add step, kept wide for overflow detection
    always_comb begin
        digit    = bcd_src[4*dig_cnt +: 4];
        acc_x    = {4'b0000, acc};
        acc_wide = (acc_x << 3) + (acc_x << 1)
                 + {{W{1'b0}}, digit};
        acc_ovf  = |acc_wide[W+3:W];
        dig_bad  = (digit > 4'd9);
        acc_last = (dig_cnt == '0);
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                accept = start;
                if (start) begin
                    state_nx = mode ? DIV : ACC;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (bit_last && dig_last) begin
                    state_nx = DONE;
                end
            end
            ACC: begin
                busy = 1'b1;
                if (acc_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                accept = start;
                if (start) begin
                    state_nx = mode ? DIV : ACC;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Working registers: capture on accept, then step each busy cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd      <= '0;
            quo      <= '0;
            rem      <= '0;
            bit_cnt  <= '0;
            dig_cnt  <= '0;
            work_bcd <= '0;
            bcd_src  <= '0;
            acc      <= '0;
            w_ovf    <= 1'b0;
            w_err    <= 1'b0;
        end else if (accept) begin
            dvd      <= bin_in;
            quo      <= '0;
            rem      <= '0;
            bit_cnt  <= '0;
            dig_cnt  <= mode ? '0 : DLAST;
            work_bcd <= '0;
            bcd_src  <= bcd_in;
            acc      <= '0;
            w_ovf    <= 1'b0;
            w_err    <= 1'b0;
        end else if (state == DIV) begin
            if (bit_last) begin
                dvd      <= quo_nx;
                quo      <= '0;
                rem      <= '0;
                bit_cnt  <= '0;
                dig_cnt  <= dig_cnt + DCW'(1);
                work_bcd <= bcd_fin;
            end else begin
                dvd     <= dvd << 1;
                quo     <= quo_nx;
                rem     <= rem_nx;
                bit_cnt <= bit_cnt + BCW'(1);
            end
        end else if (state == ACC) begin
            acc     <= acc_wide[W-1:0];
            w_ovf   <= w_ovf | acc_ovf;
            w_err   <= w_err | dig_bad;
            dig_cnt <= dig_cnt - DCW'(1);
        end
    end

    // Result registers: written only on the step that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out <= '0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else if (state == DIV && bit_last && dig_last) begin
            bcd_out <= bcd_fin;
            ovf     <= |quo_nx;
            err     <= 1'b0;
        end else if (state == ACC && acc_last) begin
            bin_out <= acc_wide[W-1:0];
            ovf     <= w_ovf | acc_ovf;
            err     <= w_err | dig_bad;
        end
    end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed bench for bcd_conv_seq: vector table plus
// hand-written start-in-busy, back-to-back and reset sequences.
module tb_bcd_conv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start_a = 1'b0;
    logic        mode_a = 1'b0;
    logic [7:0]  bin_a = '0;
    logic [11:0] bcdin_a = '0;
    logic        busy_a, done_a, ovf_a, err_a;
    logic [7:0]  binout_a;
    logic [11:0] bcdout_a;

    logic        start_b = 1'b0;
    logic        mode_b = 1'b0;
    logic [7:0]  bin_b = '0;
    logic [7:0]  bcdin_b = '0;
    logic        busy_b, done_b, ovf_b, err_b;
    logic [7:0]  binout_b;
    logic [7:0]  bcdout_b;

    int total = 0;
    int bad = 0;

    logic [7:0]  last_bin;
    logic [11:0] last_bcd;

    typedef struct {
        logic        mode;
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic [7:0]  exp_bin;
        logic [11:0] exp_bcd;
        logic        exp_ovf;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    bcd_conv_seq #(.W(8), .D(3)) u_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_a),
        .mode    (mode_a),
        .bin_in  (bin_a),
        .bcd_in  (bcdin_a),
        .busy    (busy_a),
        .done    (done_a),
        .bin_out (binout_a),
        .bcd_out (bcdout_a),
        .ovf     (ovf_a),
        .err     (err_a)
    );

    bcd_conv_seq #(.W(8), .D(2)) u_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_b),
        .mode    (mode_b),
        .bin_in  (bin_b),
        .bcd_in  (bcdin_b),
        .busy    (busy_b),
        .done    (done_b),
        .bin_out (binout_b),
        .bcd_out (bcdout_b),
        .ovf     (ovf_b),
        .err     (err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Present a request before the next edge; return #1 after that edge
    task automatic kick_a(input logic m, input logic [7:0] b,
                          input logic [11:0] c);
        @(negedge clk);
        start_a = 1'b1;
        mode_a  = m;
        bin_a   = b;
        bcdin_a = c;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic kick_b(input logic [7:0] b);
        @(negedge clk);
        start_b = 1'b1;
        mode_b  = 1'b1;
        bin_b   = b;
        @(posedge clk);
        #1;
        start_b = 1'b0;
    endtask

    // Count edges 2..lat after the start edge; done must rise exactly at lat
    task automatic wait_done(input bit sel, input int lat, input string nm);
        logic early;
        logic d;
        early = 1'b0;
        d = 1'b0;
        for (int e = 2; e <= lat; e++) begin
            @(posedge clk);
            #1;
            d = sel ? done_b : done_a;
            if (e < lat && d) early = 1'b1;
        end
        chk({nm, " early_done"}, 32'(early), 0);
        chk({nm, " done"}, 32'(d), 1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'd255, 12'h000, 8'h00, 12'h255, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'd0,   12'h000, 8'h00, 12'h000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'd99,  12'h000, 8'h00, 12'h099, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'd100, 12'h000, 8'h00, 12'h100, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'd0,   12'h123, 8'd123, 12'h000, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'd0,   12'h999, 8'd231, 12'h000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'd0,   12'h1A3, 8'd203, 12'h000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 8'd0,   12'h255, 8'd255, 12'h000, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'd0,   12'h256, 8'd0,   12'h000, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 8'd7,   12'h000, 8'h00, 12'h007, 1'b0, 1'b0};

        #1;
        chk("rst busy", 32'(busy_a), 0);
        chk("rst done", 32'(done_a), 0);
        chk("rst bin", 32'(binout_a), 0);
        chk("rst bcd", 32'(bcdout_a), 0);
        chk("rst ovf_err", {30'd0, ovf_a, err_a}, 0);
        last_bin = '0;
        last_bcd = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            kick_a(vecs[i].mode, vecs[i].bin, vecs[i].bcd);
            chk($sformatf("v%0d busy", i), 32'(busy_a), 1);
            wait_done(1'b0, vecs[i].mode ? 25 : 4, $sformatf("v%0d", i));
            chk($sformatf("v%0d ovf", i), 32'(ovf_a), 32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d err", i), 32'(err_a), 32'(vecs[i].exp_err));
            if (vecs[i].mode) begin
                chk($sformatf("v%0d bcd", i), 32'(bcdout_a),
                    32'(vecs[i].exp_bcd));
                chk($sformatf("v%0d bin_hold", i), 32'(binout_a),
                    32'(last_bin));
                last_bcd = vecs[i].exp_bcd;
            end else begin
                chk($sformatf("v%0d bin", i), 32'(binout_a),
                    32'(vecs[i].exp_bin));
                chk($sformatf("v%0d bcd_hold", i), 32'(bcdout_a),
                    32'(last_bcd));
                last_bin = vecs[i].exp_bin;
            end
        end

        // Second start while busy must be ignored
        kick_a(1'b1, 8'd123, 12'h000);
        begin
            logic early;
            early = 1'b0;
            for (int e = 2; e <= 25; e++) begin
                @(posedge clk);
                #1;
                if (e == 5) begin
                    start_a = 1'b1;
                    bin_a   = 8'd77;
                end else begin
                    start_a = 1'b0;
                end
                if (e < 25 && done_a) early = 1'b1;
            end
            chk("busy_start early_done", 32'(early), 0);
            chk("busy_start done", 32'(done_a), 1);
            chk("busy_start bcd", 32'(bcdout_a), 32'h123);
        end

        // Start held in the done cycle: new run with no idle gap
        start_a = 1'b1;
        mode_a  = 1'b1;
        bin_a   = 8'd42;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        chk("b2b busy", 32'(busy_a), 1);
        chk("b2b done_low", 32'(done_a), 0);
        wait_done(1'b0, 25, "b2b");
        chk("b2b bcd", 32'(bcdout_a), 32'h042);

        // Reset mid-division aborts with outputs cleared at once
        kick_a(1'b1, 8'd200, 12'h000);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst busy", 32'(busy_a), 0);
        chk("mid_rst bcd", 32'(bcdout_a), 0);
        chk("mid_rst bin", 32'(binout_a), 0);
        chk("mid_rst ovf_err", {30'd0, ovf_a, err_a}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                #1;
                if (done_a || busy_a) seen = 1'b1;
            end
            chk("mid_rst no_done", 32'(seen), 0);
        end
        kick_a(1'b1, 8'd42, 12'h000);
        wait_done(1'b0, 25, "post_rst");
        chk("post_rst bcd", 32'(bcdout_a), 32'h042);
        chk("post_rst ovf", 32'(ovf_a), 0);

        // Two-digit instance: overflow and zero
        kick_b(8'd200);
        wait_done(1'b1, 17, "b200");
        chk("b200 bcd", 32'(bcdout_b), 32'h00);
        chk("b200 ovf", 32'(ovf_b), 1);
        kick_b(8'd0);
        wait_done(1'b1, 17, "b0");
        chk("b0 bcd", 32'(bcdout_b), 32'h00);
        chk("b0 ovf", 32'(ovf_b), 0);
        kick_b(8'd99);
        wait_done(1'b1, 17, "b99");
        chk("b99 bcd", 32'(bcdout_b), 32'h99);
        chk("b99 ovf", 32'(ovf_b), 0);
        chk("b99 bin_hold", 32'(binout_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
